// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: window/fill history, registered match pulse.
// Define SEQ_DETECT_CNT_EN to add the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detect_prog #(
  parameter  int MAX_LEN = 16,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  input  logic               clear,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               flag,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] window_n;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_n;
  logic               step;
  logic               hit;

  assign cfg_err = (len == '0) || (len > LEN_W'(MAX_LEN));
  assign step    = en && !clear;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    window_n = {window[MAX_LEN-2:0], din};
    fill_n   = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
  end

  // Only the low len bits take part in the comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign hit = step && !cfg_err && (fill_n >= len) &&
               (((window_n ^ pattern) & mask) == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
      fill   <= '0;
      flag   <= 1'b0;
    end else if (clear) begin
      window <= '0;
      fill   <= '0;
      flag   <= 1'b0;
    end else begin
      flag <= hit;
      if (en) begin
        window <= window_n;
        // Non-overlapping mode restarts the fill; stale window bits become unusable.
        fill   <= (hit && !overlap) ? '0 : fill_n;
      end
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (hit && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios plus randomized traffic
// compared every cycle against a bit-history model.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               en;
  logic               din;
  logic               clear;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic               flag;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .clear     (clear),
    .pattern   (pattern),
    .len       (len),
    .overlap   (overlap),
    .flag      (flag),
    .match_cnt (match_cnt),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bits received since the last restart, newest at the back.
  bit hist[$];
  bit m_flag = 1'b0;
  int m_cnt  = 0;

  function automatic bit cfg_bad();
    return (int'(len) == 0) || (int'(len) > MAX_LEN);
  endfunction

  function automatic bit tail_match();
    int n = int'(len);
    if (hist.size() < n) return 1'b0;
    for (int k = 0; k < n; k++) begin
      if (hist[hist.size() - 1 - k] != pattern[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      hist.delete();
      m_flag = 1'b0;
      m_cnt  = 0;
    end else if (en) begin
      hist.push_back(din);
      if (hist.size() > 64) void'(hist.pop_front());
      m_flag = !cfg_bad() && tail_match();
      if (m_flag) begin
        if (CNT_ON && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!overlap) hist.delete();
      end
    end else begin
      m_flag = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("flag", flag, m_flag);
    check("match_cnt", match_cnt, m_cnt);
    check("cfg_err", cfg_err, cfg_bad());
  end

  // Inputs change 1 time unit after a rising edge; the task returns 1 unit after the next edge.
  task automatic cycle(input logic e, input logic d);
    en = e;
    din = d;
    clear = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    en = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i]);
  endtask

  int flags_seen;

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; clear = 1'b0;
    pattern = '0; len = LEN_W'(8); overlap = 1'b0;
    #7;
    check("reset_flag", flag, 0);
    check("reset_cnt", match_cnt, 0);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    // Overlapping 0x55 over 0101010101: pulses after bits 8 and 10.
    pattern = 16'h0055; len = LEN_W'(8); overlap = 1'b1;
    send_bits(64'b01010101, 8);
    check("ov_flag_b8", flag, 1);
    cycle(1'b1, 1'b0);
    check("ov_flag_b9", flag, 0);
    cycle(1'b1, 1'b1);
    check("ov_flag_b10", flag, 1);
    check("ov_cnt", match_cnt, CNT_ON ? 2 : 0);

    // Non-overlapping: pulse after bit 8, next one only after bit 16.
    do_clear();
    check("clear_flag", flag, 0);
    check("clear_cnt", match_cnt, 0);
    overlap = 1'b0;
    send_bits(64'b01010101, 8);
    check("nov_flag_b8", flag, 1);
    send_bits(64'b01, 2);
    check("nov_flag_b10", flag, 0);
    send_bits(64'b010101, 6);
    check("nov_flag_b16", flag, 1);
    check("nov_cnt", match_cnt, CNT_ON ? 2 : 0);

    // Enable gaps do not break a partial match.
    do_clear();
    len = LEN_W'(4); pattern = 16'h000B; overlap = 1'b1;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    flags_seen = 0;
    repeat (5) begin
      cycle(1'b0, 1'($urandom));
      if (flag) flags_seen++;
    end
    check("gap_no_flag", flags_seen, 0);
    cycle(1'b1, 1'b1);
    check("gap_flag_3rd", flag, 0);
    cycle(1'b1, 1'b1);
    check("gap_flag_last", flag, 1);

    // Illegal lengths: cfg_err high and no flag; history still shifts.
    len = '0; pattern = '0;
    #1 check("cfg_len0", cfg_err, 1);
    flags_seen = 0;
    repeat (20) begin
      cycle(1'b1, 1'b0);
      if (flag) flags_seen++;
    end
    check("len0_no_flag", flags_seen, 0);
    len = LEN_W'(MAX_LEN + 1); pattern = '1;
    #1 check("cfg_len17", cfg_err, 1);
    flags_seen = 0;
    repeat (20) begin
      cycle(1'b1, 1'b1);
      if (flag) flags_seen++;
    end
    check("len17_no_flag", flags_seen, 0);
    len = LEN_W'(MAX_LEN);
    #1 check("cfg_len16", cfg_err, 0);

    // Counter saturation: five matches of "11".
    do_clear();
    len = LEN_W'(2); pattern = 16'h0003; overlap = 1'b1;
    repeat (6) cycle(1'b1, 1'b1);
    check("sat_cnt", match_cnt, CNT_ON ? 3 : 0);

    // Asynchronous reset mid-cycle after 5 of 8 bits; the next match needs fresh bits.
    len = LEN_W'(8); pattern = 16'h0055;
    send_bits(64'b01010, 5);
    check("pre_rst_cnt", match_cnt, CNT_ON ? 3 : 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_flag", flag, 0);
    check("async_rst_cnt", match_cnt, 0);
    #2 rst = 1'b0;
    flags_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'(3'b101 >> (2 - i)));
      if (flag) flags_seen++;
    end
    check("post_rst_no_flag", flags_seen, 0);
    send_bits(64'b01010101, 8);

    // Randomized traffic checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        len = ($urandom_range(0, 9) < 6) ? LEN_W'($urandom_range(1, 4))
                                         : LEN_W'($urandom_range(0, MAX_LEN + 1));
        pattern = MAX_LEN'($urandom);
        overlap = 1'($urandom);
      end
      en = ($urandom_range(0, 3) != 0);
      din = 1'($urandom);
      clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
